// File: rtl/tx_byte_fifo.sv
// Byte FIFO that feeds a serial transmitter one launch at a time.
// A stalled transmitter (never goes busy) sets a sticky error flag.
module tx_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic        ovf,
  output logic        TxD_start,
  output logic [7:0]  TxD_data,
  input  logic        TxD_busy,
  output logic        tx_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          start_q, start_d;
  logic [7:0]    data_q, data_d;
  logic          err_q, err_d;
  logic [2:0]    timer_q, timer_d;
  state_e        state_q, state_d;
  logic          push, pop;

  // Full is the registered flag, so a same-cycle pop never frees a slot.
  always_comb begin
    push     = wr_en & ~full_q;
    pop      = (state_q == IDLE) & ~empty_q & ~TxD_busy;
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
    ovf_d   = wr_en & full_q;
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    err_d   = err_q;
    start_d = 1'b0;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          start_d = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          timer_d = '0;
          state_d = ARM;
        end
      end
      ARM: begin
        if (TxD_busy) begin
          state_d = DRAIN;
        end else begin
          timer_d = timer_q + 3'd1;
          // No acknowledge in time: the launched byte is abandoned.
          if (timer_d == 3'd7) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (!TxD_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      start_q  <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
      timer_q  <= '0;
      state_q  <= IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      start_q  <= start_d;
      data_q   <= data_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
      state_q  <= state_d;
    end
  end

  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign ovf       = ovf_q;
  assign TxD_start = start_q;
  assign TxD_data  = data_q;
  assign tx_err    = err_q;

endmodule

// File: tb/tb_tx_byte_fifo.sv
// Bench for tx_byte_fifo: queue scoreboard plus a transmitter model.
// Model modes: normal busy pulse, dead (never busy), hold (always busy).
module tb_tx_byte_fifo;

  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int NORMAL = 0;
  localparam int DEAD   = 1;
  localparam int HOLD   = 2;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        TxD_busy = 1'b0;
  logic        full, empty, ovf;
  logic        TxD_start, tx_err;
  logic [AW:0] count;
  logic [7:0]  TxD_data;

  int n_cmp = 0;
  int n_err = 0;
  int tx_mode = NORMAL;
  int busy_len = 4;
  int n_launch = 0;
  int n_acc = 0;
  int n_ovf_seen = 0;
  logic [7:0] refq[$];
  logic [7:0] last_data = 8'h00;
  logic [7:0] exp_b;
  bit pend = 0;
  bit prev_start = 0;
  int rem = 0;

  always #5 clk = ~clk;

  tx_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .RST      (RST),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .ovf      (ovf),
    .TxD_start(TxD_start),
    .TxD_data (TxD_data),
    .TxD_busy (TxD_busy),
    .tx_err   (tx_err)
  );

  // Transmitter model and launch scoreboard, sampled 1ns after each edge.
  always @(posedge clk) begin
    #1;
    if (!RST) begin
      pend = 0;
      rem = 0;
      TxD_busy = 1'b0;
      prev_start = 0;
      last_data = 8'h00;
    end else begin
      if (tx_mode == HOLD) begin
        TxD_busy = 1'b1;
      end else if (pend) begin
        TxD_busy = 1'b1;
        rem = busy_len;
        pend = 0;
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) TxD_busy = 1'b0;
      end else begin
        TxD_busy = 1'b0;
      end
      if (TxD_start === 1'b1) begin
        n_launch++;
        n_cmp++;
        if (refq.size() == 0) begin
          n_err++;
          $display("FAIL launch_unexpected: got byte %h, queue empty",
                   TxD_data);
        end else begin
          exp_b = refq.pop_front();
          if (TxD_data !== exp_b) begin
            n_err++;
            $display("FAIL launch_data: got %h, expected %h",
                     TxD_data, exp_b);
          end
        end
        n_cmp++;
        if (prev_start) begin
          n_err++;
          $display("FAIL start_pulse: got start high 2 cycles, expected 1");
        end
        last_data = TxD_data;
        if (tx_mode == NORMAL) pend = 1;
      end else begin
        n_cmp++;
        if (TxD_data !== last_data) begin
          n_err++;
          $display("FAIL data_hold: got %h, expected %h",
                   TxD_data, last_data);
        end
      end
      prev_start = (TxD_start === 1'b1);
    end
  end

  // One cycle: drive at negedge, account at posedge, check at negedge.
  task automatic step(input logic we, input logic [7:0] d);
    logic drop;
    logic [AW:0] ec;
    wr_en = we;
    wr_data = d;
    @(posedge clk);
    drop = 1'b0;
    if (we) begin
      if (refq.size() < DEPTH) begin
        refq.push_back(d);
        n_acc++;
      end else begin
        drop = 1'b1;
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
    ec = (AW+1)'(refq.size());
    if (ovf === 1'b1) n_ovf_seen++;
    n_cmp++;
    if (ovf !== drop) begin
      n_err++;
      $display("FAIL ovf: got %b, expected %b", ovf, drop);
    end
    n_cmp++;
    if (count !== ec) begin
      n_err++;
      $display("FAIL count: got %0d, expected %0d", count, ec);
    end
    n_cmp++;
    if (empty !== (ec == 0)) begin
      n_err++;
      $display("FAIL empty: got %b, expected %b", empty, ec == 0);
    end
    n_cmp++;
    if (full !== (ec == DEPTH)) begin
      n_err++;
      $display("FAIL full: got %b, expected %b", full, ec == DEPTH);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    RST = 1'b0;
    wr_en = 1'b0;
    refq.delete();
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while (refq.size() != 0 && c < maxc) begin
      step(1'b0, 8'h00);
      c++;
    end
    n_cmp++;
    if (refq.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d queued, expected 0",
               refq.size());
    end
    repeat (busy_len + 4) step(1'b0, 8'h00);
  endtask

  task automatic test_reset();
    #2 RST = 1'b0;
    #1;
    n_cmp += 7;
    if (count !== '0) begin
      n_err++; $display("FAIL rst_count: got %0d, expected 0", count);
    end
    if (empty !== 1'b1) begin
      n_err++; $display("FAIL rst_empty: got %b, expected 1", empty);
    end
    if (full !== 1'b0) begin
      n_err++; $display("FAIL rst_full: got %b, expected 0", full);
    end
    if (TxD_start !== 1'b0) begin
      n_err++; $display("FAIL rst_start: got %b, expected 0", TxD_start);
    end
    if (TxD_data !== 8'h00) begin
      n_err++; $display("FAIL rst_data: got %h, expected 00", TxD_data);
    end
    if (ovf !== 1'b0) begin
      n_err++; $display("FAIL rst_ovf: got %b, expected 0", ovf);
    end
    if (tx_err !== 1'b0) begin
      n_err++; $display("FAIL rst_txerr: got %b, expected 0", tx_err);
    end
    @(negedge clk);
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int l0;
    tx_mode = NORMAL;
    busy_len = 100;
    do_reset();
    l0 = n_launch;
    step(1'b1, 8'hA5);
    n_cmp++;
    if (n_launch != l0) begin
      n_err++; $display("FAIL single_early: got %0d launches, expected 0",
                        n_launch - l0);
    end
    step(1'b0, 8'h00);
    n_cmp++;
    if (TxD_start !== 1'b1 || n_launch != l0 + 1) begin
      n_err++; $display("FAIL single_latency: got start=%b n=%0d, expected 1 1",
                        TxD_start, n_launch - l0);
    end
    repeat (120) step(1'b0, 8'h00);
    n_cmp += 2;
    if (n_launch != l0 + 1) begin
      n_err++; $display("FAIL single_count: got %0d launches, expected 1",
                        n_launch - l0);
    end
    if (tx_err !== 1'b0) begin
      n_err++; $display("FAIL single_txerr: got %b, expected 0", tx_err);
    end
  endtask

  task automatic test_fill_ovf();
    int l0;
    tx_mode = HOLD;
    do_reset();
    l0 = n_launch;
    n_ovf_seen = 0;
    for (int i = 0; i < 17; i++) step(1'b1, 8'(i));
    n_cmp += 4;
    if (full !== 1'b1) begin
      n_err++; $display("FAIL fill_full: got %b, expected 1", full);
    end
    if (count !== 5'd16) begin
      n_err++; $display("FAIL fill_count: got %0d, expected 16", count);
    end
    if (n_ovf_seen != 1) begin
      n_err++; $display("FAIL fill_ovf_pulses: got %0d, expected 1",
                        n_ovf_seen);
    end
    if (n_launch != l0) begin
      n_err++; $display("FAIL fill_nolaunch: got %0d, expected 0",
                        n_launch - l0);
    end
    tx_mode = NORMAL;
    busy_len = 2;
    drain(400);
    n_cmp++;
    if (n_launch != l0 + 16) begin
      n_err++; $display("FAIL fill_drained: got %0d launches, expected 16",
                        n_launch - l0);
    end
  endtask

  task automatic test_order_wrap();
    int l0, a0, guard, nb;
    tx_mode = NORMAL;
    do_reset();
    l0 = n_launch;
    a0 = n_acc;
    guard = 0;
    while (n_acc - a0 < 40 && guard < 200) begin
      busy_len = $urandom_range(1, 4);
      nb = $urandom_range(1, 8);
      for (int k = 0; k < nb; k++) step(1'b1, 8'($urandom));
      repeat ($urandom_range(0, 12)) step(1'b0, 8'h00);
      guard++;
    end
    drain(1000);
    n_cmp++;
    if (n_launch - l0 != n_acc - a0) begin
      n_err++; $display("FAIL order_total: got %0d launches, expected %0d",
                        n_launch - l0, n_acc - a0);
    end
  endtask

  task automatic test_simul();
    tx_mode = HOLD;
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'h50 + 8'(i));
    tx_mode = NORMAL;
    busy_len = 3;
    step(1'b0, 8'h00);
    step(1'b1, 8'hEE);
    n_cmp += 2;
    if (count !== 5'd5) begin
      n_err++; $display("FAIL simul_count: got %0d, expected 5", count);
    end
    if (TxD_start !== 1'b1) begin
      n_err++; $display("FAIL simul_pop: got start %b, expected 1",
                        TxD_start);
    end
    drain(300);
  endtask

  task automatic test_dead_tx();
    int l0;
    logic e;
    tx_mode = DEAD;
    do_reset();
    l0 = n_launch;
    step(1'b1, 8'h3C);
    step(1'b1, 8'h5A);
    n_cmp++;
    if (TxD_start !== 1'b1 || n_launch != l0 + 1) begin
      n_err++; $display("FAIL dead_launch: got start=%b n=%0d, expected 1 1",
                        TxD_start, n_launch - l0);
    end
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 8'h00);
      e = (k == 7);
      n_cmp++;
      if (tx_err !== e) begin
        n_err++; $display("FAIL dead_txerr_%0d: got %b, expected %b",
                          k, tx_err, e);
      end
    end
    n_cmp++;
    if (n_launch != l0 + 1) begin
      n_err++; $display("FAIL dead_arm_hold: got %0d, expected 1",
                        n_launch - l0);
    end
    step(1'b0, 8'h00);
    n_cmp++;
    if (TxD_start !== 1'b1 || n_launch != l0 + 2) begin
      n_err++; $display("FAIL dead_relaunch: got start=%b n=%0d, expected 1 2",
                        TxD_start, n_launch - l0);
    end
  endtask

  task automatic test_midreset();
    int l0;
    tx_mode = NORMAL;
    busy_len = 30;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'hC0 + 8'(i));
    repeat (3) step(1'b0, 8'h00);
    n_cmp++;
    if (count !== 5'd3) begin
      n_err++; $display("FAIL mid_queued: got %0d, expected 3", count);
    end
    RST = 1'b0;
    refq.delete();
    #1;
    n_cmp += 4;
    if (count !== '0 || empty !== 1'b1) begin
      n_err++; $display("FAIL mid_flush: got count=%0d empty=%b, expected 0 1",
                        count, empty);
    end
    if (full !== 1'b0) begin
      n_err++; $display("FAIL mid_full: got %b, expected 0", full);
    end
    if (TxD_start !== 1'b0) begin
      n_err++; $display("FAIL mid_start: got %b, expected 0", TxD_start);
    end
    if (tx_err !== 1'b0) begin
      n_err++; $display("FAIL mid_txerr: got %b, expected 0", tx_err);
    end
    @(negedge clk);
    @(negedge clk);
    RST = 1'b1;
    l0 = n_launch;
    repeat (40) step(1'b0, 8'h00);
    n_cmp++;
    if (n_launch != l0) begin
      n_err++; $display("FAIL mid_nolaunch: got %0d launches, expected 0",
                        n_launch - l0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_ovf();
    test_order_wrap();
    test_simul();
    test_dead_tx();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tx_byte_fifo.md
TX_BYTE_FIFO -- requirements
Module: tx_byte_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in bytes (power of two, 4..256).
REQ-002 SHALL have parameter AW, default 4, pointer width; AW SHALL equal log2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous active-low reset; RST=0 resets all state immediately.
REQ-005 SHALL have port wr_en  input  1  push request for wr_data this cycle.
REQ-006 SHALL have port wr_data  input  8  byte to enqueue.
REQ-007 SHALL have port full  output  1  FIFO holds DEPTH bytes.
REQ-008 SHALL have port empty  output  1  FIFO holds 0 bytes.
REQ-009 SHALL have port count  output  AW+1  current occupancy, 0..DEPTH.
REQ-010 SHALL have port ovf  output  1  one-cycle pulse when a push is dropped.
REQ-011 SHALL have port TxD_start  output  1  one-cycle launch strobe to the serial transmitter.
REQ-012 SHALL have port TxD_data  output  8  byte presented to the transmitter.
REQ-013 SHALL have port TxD_busy  input  1  transmitter busy; rises one cycle after an accepted TxD_start.
REQ-014 SHALL have port tx_err  output  1  sticky flag: transmitter failed to acknowledge a launch.

Function
REQ-015 SHALL accept a push when wr_en=1 and full=0: write wr_data at wr_ptr, increment wr_ptr modulo DEPTH.
REQ-016 SHALL drop a push when wr_en=1 and full=1, leaving contents unchanged, and assert ovf on the following cycle for exactly one cycle.
REQ-017 SHALL judge full from the registered state at the push edge; a pop in the same cycle does not make room for that push.
REQ-018 SHALL update count by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop.
REQ-019 SHALL derive full=(count==DEPTH) and empty=(count==0), both registered.
REQ-020 SHALL wrap both pointers from DEPTH-1 to 0 without loss or duplication.
REQ-021 SHALL implement drain FSM states IDLE, ARM and DRAIN.
REQ-022 In IDLE with empty=0 and TxD_busy=0, the edge SHALL: load TxD_data with mem[rd_ptr], increment rd_ptr, set TxD_start=1, clear the arm timer, and enter ARM.
REQ-023 TxD_start SHALL be high for exactly one cycle per popped byte; the next edge clears it.
REQ-024 In ARM, TxD_busy=1 SHALL cause a move to DRAIN; otherwise the 3-bit arm timer increments.
REQ-025 In ARM, if the arm timer reaches 7 with TxD_busy=0, the FSM SHALL set tx_err=1 and return to IDLE; the byte is lost.
REQ-026 In DRAIN, TxD_busy=0 SHALL cause a move to IDLE; the FSM SHALL wait in DRAIN indefinitely otherwise.
REQ-027 SHALL hold TxD_data stable from launch until the next pop.
REQ-028 Back-to-back launch latency SHALL be 1 cycle from TxD_busy falling, sampled in DRAIN, through IDLE to TxD_start=1 at 2 edges later.
REQ-029 First-byte latency SHALL be: push at edge N, empty=0 after N, TxD_start=1 after edge N+1.

Reset
REQ-030 On RST=0, the block SHALL asynchronously clear wr_ptr, rd_ptr, count, TxD_start, TxD_data, ovf, tx_err and the arm timer, set empty=1 and full=0, and force state IDLE.
REQ-031 SHALL treat RST asserted mid-transmission as a flush: queued bytes are discarded and no TxD_start is issued until RST=1 and a new push occurs.
REQ-032 SHALL leave memory contents undefined after reset; they are never observable because count=0.

Verification
REQ-033 The bench SHALL cover single byte: push 0xA5 with a transmitter model whose busy lasts 100 cycles -> exactly one TxD_start with TxD_data=0xA5, empty=1 after pop, tx_err=0.
REQ-034 The bench SHALL cover fill and overflow: hold model busy, push 17 bytes 0x00..0x10 -> full=1, count=16, one ovf pulse on the 17th, byte 0x10 never transmitted.
REQ-035 The bench SHALL cover order and wrap: push 40 bytes in bursts with interleaved drains -> transmitted sequence equals pushed sequence, pointers wrap at least twice.
REQ-036 The bench SHALL cover simultaneous push and pop at count=5 -> count stays 5 and the new byte appears at the tail.
REQ-037 The bench SHALL cover a dead transmitter: tie TxD_busy=0, push 0x3C -> TxD_start pulse, 7 cycles later tx_err=1, FSM in IDLE, next byte launches.
REQ-038 The bench SHALL cover mid-operation reset: assert RST=0 in DRAIN with 3 bytes queued -> immediately count=0, empty=1, TxD_start=0, tx_err=0; no launches after release.
